// File: rtl/cog_loader.sv
// cog_loader: cog start-up sequencer and cog RAM port arbiter.
// On an accepted start pulse it reads LOAD_LONGS consecutive longs from hub
// memory (starting at the captured hub long address) and writes them to cog
// RAM addresses 0..LOAD_LONGS-1, then returns the RAM port to the cog pipeline.
// While idle the cog pipeline's RAM port is passed straight through.
//
// Build option: define COG_LOADER_ZERO_EN to zero-fill cog RAM addresses
// LOAD_LONGS..511 after the image has been loaded. Without it those
// addresses keep their previous contents.
module cog_loader #(
   parameter int LOAD_LONGS = 496,
   parameter int HUB_AW     = 14
) (
   input  logic              clk,
   input  logic              nres,
   input  logic              start,
   input  logic [HUB_AW-1:0] ptr,
   output logic              busy,
   output logic              done,
   output logic              hub_req,
   output logic [HUB_AW-1:0] hub_adr,
   input  logic              hub_ack,
   input  logic [31:0]       hub_q,
   input  logic              cog_ena,
   input  logic              cog_w,
   input  logic [8:0]        cog_a,
   input  logic [31:0]       cog_d,
   output logic              ram_ena,
   output logic              ram_w,
   output logic [8:0]        ram_a,
   output logic [31:0]       ram_d
);

   // FSM encoding
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_REQ   = 3'd1;
   localparam logic [2:0] ST_WRITE = 3'd2;
`ifdef COG_LOADER_ZERO_EN
   localparam logic [2:0] ST_ZERO  = 3'd3;
`endif
   localparam logic [2:0] ST_DONE  = 3'd4;

   // Index of the last image long; the write at this index ends the load phase
   localparam logic [9:0] LAST_IDX = 10'(LOAD_LONGS - 1);
   // Highest cog RAM address, used to terminate the zero-fill phase
   localparam logic [9:0] TOP_IDX  = 10'd511;

`ifdef COG_LOADER_ZERO_EN
   // A full-size image leaves nothing to clear, so zero-fill is skipped
   localparam logic ZERO_FILL = (LOAD_LONGS < 512);
`endif

   // Sequencer state
   logic [2:0]        state_q,   state_d;
   logic [HUB_AW-1:0] base_q,    base_d;
   logic [9:0]        cnt_q,     cnt_d;
   logic [31:0]       data_q,    data_d;

   // Registered outputs, derived from the next state so they line up with it
   logic              busy_q,    busy_d;
   logic              done_q,    done_d;
   logic              hub_req_q, hub_req_d;
   logic [HUB_AW-1:0] hub_adr_q, hub_adr_d;

   // Long counter widened to the hub address width for the address adder
   logic [HUB_AW-1:0] cnt_ext_s;

   // Next-state logic for the load sequencer
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d  = ptr;
               cnt_d   = 10'd0;
               state_d = ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            // hub_q is only valid in the ack cycle, so capture it here
            if (hub_ack) begin
               data_d  = hub_q;
               state_d = ST_WRITE;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_WRITE: begin
            if (cnt_q == LAST_IDX) begin
`ifdef COG_LOADER_ZERO_EN
               if (ZERO_FILL) begin
                  // Counter keeps running so it addresses the fill region
                  cnt_d   = cnt_q + 10'd1;
                  state_d = ST_ZERO;
               end else begin
                  state_d = ST_DONE;
               end
`else
               state_d = ST_DONE;
`endif
            end else begin
               cnt_d   = cnt_q + 10'd1;
               state_d = ST_REQ;
            end
         end
`ifdef COG_LOADER_ZERO_EN
         ST_ZERO: begin
            if (cnt_q == TOP_IDX) begin
               state_d = ST_DONE;
            end else begin
               cnt_d   = cnt_q + 10'd1;
               state_d = ST_ZERO;
            end
         end
`endif
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output register next values; hub address wraps silently at 2^HUB_AW
   always_comb begin
      cnt_ext_s = HUB_AW'(cnt_d);
      busy_d    = (state_d != ST_IDLE);
      done_d    = (state_d == ST_DONE);
      hub_req_d = (state_d == ST_REQ);
      hub_adr_d = base_d + cnt_ext_s;
   end

   // State and output registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge nres) begin
      if (!nres) begin
         state_q   <= ST_IDLE;
         base_q    <= '0;
         cnt_q     <= 10'd0;
         data_q    <= 32'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hub_req_q <= 1'b0;
         hub_adr_q <= '0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         hub_req_q <= hub_req_d;
         hub_adr_q <= hub_adr_d;
      end
   end

   // Cog RAM port arbiter: cog pipeline when idle, loader otherwise
   always_comb begin
      if (state_q == ST_IDLE) begin
         ram_ena = cog_ena;
         ram_w   = cog_w;
         ram_a   = cog_a;
         ram_d   = cog_d;
      end else begin
         // Cog requests are dropped while the loader owns the port
         ram_ena = 1'b0;
         ram_w   = 1'b0;
         ram_a   = cnt_q[8:0];
         ram_d   = data_q;
         case (state_q)
            ST_WRITE: begin
               ram_ena = 1'b1;
               ram_w   = 1'b1;
            end
`ifdef COG_LOADER_ZERO_EN
            ST_ZERO: begin
               ram_ena = 1'b1;
               ram_w   = 1'b1;
               ram_d   = 32'd0;
            end
`endif
            default: begin
               ram_ena = 1'b0;
               ram_w   = 1'b0;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign hub_req = hub_req_q;
   assign hub_adr = hub_adr_q;

endmodule

// File: tb/tb_cog_loader.sv
// tb_cog_loader: directed bench for cog_loader. A 4-long instance covers the
// main scenarios, a 512-long instance covers the full-RAM boundary and, when
// COG_LOADER_ZERO_EN is defined, a 496-long instance covers zero-fill.
`timescale 1ns/1ps
module tb_cog_loader;

`ifdef COG_LOADER_ZERO_EN
   localparam int ZF4 = 508;
`else
   localparam int ZF4 = 0;
`endif
   localparam int LIMIT = 700;

   logic clk = 1'b0;
   logic nres;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- 4-long instance ----------------
   logic        start, busy, done, hub_req, hub_ack;
   logic [13:0] ptr, hub_adr;
   logic [31:0] hub_q, cog_d, ram_d;
   logic        cog_ena, cog_w, ram_ena, ram_w;
   logic [8:0]  cog_a, ram_a;
   int          ack_mode = 0;
   int          req_age = 0;

   assign hub_q   = 32'hA000_0000 + {18'd0, hub_adr};
   assign hub_ack = (ack_mode == 2) ? 1'b1 :
                    (ack_mode == 1) ? (hub_req && (req_age == 3)) : hub_req;

   // cycles hub_req has already been high, for the delayed-ack hub
   always @(posedge clk) begin
      if (hub_req) req_age <= req_age + 1;
      else         req_age <= 0;
   end

   logic [31:0] mem [0:511];
   // cog RAM model
   always @(posedge clk) begin
      if (ram_ena && ram_w) mem[ram_a] <= ram_d;
   end

   cog_loader #(.LOAD_LONGS(4), .HUB_AW(14)) dut (
      .clk(clk), .nres(nres), .start(start), .ptr(ptr), .busy(busy), .done(done),
      .hub_req(hub_req), .hub_adr(hub_adr), .hub_ack(hub_ack), .hub_q(hub_q),
      .cog_ena(cog_ena), .cog_w(cog_w), .cog_a(cog_a), .cog_d(cog_d),
      .ram_ena(ram_ena), .ram_w(ram_w), .ram_a(ram_a), .ram_d(ram_d));

   // ---------------- 512-long instance ----------------
   logic        start2, busy2, done2, hub_req2, ram_ena2, ram_w2;
   logic [13:0] ptr2, hub_adr2;
   logic [31:0] hub_q2, ram_d2;
   logic [8:0]  ram_a2;
   logic        ack_one = 1'b1;
   assign hub_q2 = 32'h5A00_0000 | {18'd0, hub_adr2};

   cog_loader #(.LOAD_LONGS(512), .HUB_AW(14)) dut512 (
      .clk(clk), .nres(nres), .start(start2), .ptr(ptr2), .busy(busy2), .done(done2),
      .hub_req(hub_req2), .hub_adr(hub_adr2), .hub_ack(ack_one), .hub_q(hub_q2),
      .cog_ena(cog_ena), .cog_w(cog_w), .cog_a(cog_a), .cog_d(cog_d),
      .ram_ena(ram_ena2), .ram_w(ram_w2), .ram_a(ram_a2), .ram_d(ram_d2));

`ifdef COG_LOADER_ZERO_EN
   // ---------------- 496-long zero-fill instance ----------------
   logic        start3, busy3, done3, hub_req3, ram_ena3, ram_w3;
   logic [13:0] ptr3, hub_adr3;
   logic [31:0] hub_q3, ram_d3;
   logic [8:0]  ram_a3;
   assign hub_q3 = 32'hC000_0000 | {18'd0, hub_adr3};

   cog_loader #(.LOAD_LONGS(496), .HUB_AW(14)) dut496 (
      .clk(clk), .nres(nres), .start(start3), .ptr(ptr3), .busy(busy3), .done(done3),
      .hub_req(hub_req3), .hub_adr(hub_adr3), .hub_ack(ack_one), .hub_q(hub_q3),
      .cog_ena(cog_ena), .cog_w(cog_w), .cog_a(cog_a), .cog_d(cog_d),
      .ram_ena(ram_ena3), .ram_w(ram_w3), .ram_a(ram_a3), .ram_d(ram_d3));
`endif

   // Pulse start for one cycle; returns at the negedge of cycle 1
   task automatic start_load(input logic [13:0] p);
      @(negedge clk);
      ptr = p;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset;
      nres = 1'b0;
      cog_ena = 1'b1; cog_w = 1'b0; cog_a = 9'h155; cog_d = 32'h1234_5678;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy, done, hub_req, hub_adr} !== 17'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: busy=%b done=%b hub_req=%b hub_adr=%h, required all 0",
                  busy, done, hub_req, hub_adr);
      end
      n_cmp++;
      if ({ram_ena, ram_w, ram_a, ram_d} !== {1'b1, 1'b0, 9'h155, 32'h1234_5678}) begin
         n_bad++;
         $display("FAIL reset_passthrough: ram=%b %b %h %h, required 1 0 155 12345678",
                  ram_ena, ram_w, ram_a, ram_d);
      end
      @(negedge clk);
      nres = 1'b1;
      cog_ena = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int cyc, done_cyc;
      logic busy_at_done;
      ack_mode = 0;
      start_load(14'h0100);
      n_cmp++;
      if ({busy, hub_req, hub_adr} !== {1'b1, 1'b1, 14'h0100}) begin
         n_bad++;
         $display("FAIL basic_cycle1: busy=%b hub_req=%b hub_adr=%h, required 1 1 0100",
                  busy, hub_req, hub_adr);
      end
      cyc = 1; done_cyc = -1; busy_at_done = 1'b0;
      while (done_cyc < 0 && cyc < LIMIT) begin
         if (done === 1'b1) begin
            done_cyc = cyc;
            busy_at_done = busy;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      n_cmp++;
      if (done_cyc != 9 + ZF4 || busy_at_done !== 1'b1) begin
         n_bad++;
         $display("FAIL basic_done: done at cycle %0d busy=%b, required %0d busy=1",
                  done_cyc, busy_at_done, 9 + ZF4);
      end
      @(negedge clk);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_bad++;
         $display("FAIL basic_after_done: busy=%b done=%b, required 0 0", busy, done);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (mem[i] !== 32'hA000_0100 + i) begin
            n_bad++;
            $display("FAIL basic_ram[%0d]: got %h, required %h", i, mem[i], 32'hA000_0100 + i);
         end
      end
   endtask

   // Entered at the first cycle busy reads 0; start raised right there
   task automatic test_back_to_back;
      int cyc, done_cyc;
      ptr = 14'h0140;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if ({hub_req, hub_adr} !== {1'b1, 14'h0140}) begin
         n_bad++;
         $display("FAIL b2b_accept: hub_req=%b hub_adr=%h, required 1 0140", hub_req, hub_adr);
      end
      cyc = 1; done_cyc = -1;
      while (done_cyc < 0 && cyc < LIMIT) begin
         if (done === 1'b1) done_cyc = cyc;
         else begin @(negedge clk); cyc++; end
      end
      @(negedge clk);
      n_cmp++;
      if (done_cyc != 9 + ZF4 || mem[0] !== 32'hA000_0140) begin
         n_bad++;
         $display("FAIL b2b_load: done cycle %0d ram[0]=%h, required %0d A0000140",
                  done_cyc, mem[0], 9 + ZF4);
      end
   endtask

   task automatic test_ack_latency;
      int cyc, done_cyc, unstable, writes, acks;
      logic prev_req;
      logic [13:0] prev_adr;
      ack_mode = 1;
      start_load(14'h0200);
      cyc = 1; done_cyc = -1; unstable = 0; writes = 0; acks = 0;
      prev_req = 1'b0; prev_adr = 14'd0;
      while (done_cyc < 0 && cyc < LIMIT) begin
         if (hub_req && prev_req && hub_adr !== prev_adr) unstable++;
         if (hub_req && hub_ack) acks++;
         if (ram_ena && ram_w && ram_a < 9'd4) writes++;
         prev_req = hub_req;
         prev_adr = hub_adr;
         if (done === 1'b1) done_cyc = cyc;
         else begin @(negedge clk); cyc++; end
      end
      n_cmp++;
      if (unstable != 0) begin
         n_bad++;
         $display("FAIL lat_adr_stable: %0d changes while hub_req, required 0", unstable);
      end
      n_cmp++;
      if (writes != 4 || acks != 4) begin
         n_bad++;
         $display("FAIL lat_counts: writes=%0d acks=%0d, required 4 4", writes, acks);
      end
      n_cmp++;
      if (done_cyc != 21 + ZF4) begin
         n_bad++;
         $display("FAIL lat_done: done at cycle %0d, required %0d", done_cyc, 21 + ZF4);
      end
      @(negedge clk);
      n_cmp++;
      if (mem[3] !== 32'hA000_0203) begin
         n_bad++;
         $display("FAIL lat_ram3: got %h, required A0000203", mem[3]);
      end
      ack_mode = 0;
   endtask

   task automatic test_wrap;
      int cyc, idx;
      logic [13:0] got [0:3];
      logic [13:0] exp_adr [0:3];
      exp_adr[0] = 14'h3FFE; exp_adr[1] = 14'h3FFF; exp_adr[2] = 14'h0000; exp_adr[3] = 14'h0001;
      for (int i = 0; i < 4; i++) got[i] = 14'h2AAA;
      ack_mode = 0;
      start_load(14'h3FFE);
      cyc = 1; idx = 0;
      while (done !== 1'b1 && cyc < LIMIT) begin
         if (hub_req && hub_ack && idx < 4) begin
            got[idx] = hub_adr;
            idx++;
         end
         @(negedge clk);
         cyc++;
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (got[i] !== exp_adr[i]) begin
            n_bad++;
            $display("FAIL wrap_adr[%0d]: got %h, required %h", i, got[i], exp_adr[i]);
         end
      end
      @(negedge clk);
      n_cmp++;
      if (mem[2] !== 32'hA000_0000 || mem[1] !== 32'hA000_3FFF) begin
         n_bad++;
         $display("FAIL wrap_ram: ram[1]=%h ram[2]=%h, required A0003FFF A0000000", mem[1], mem[2]);
      end
   endtask

   task automatic test_arbitration;
      int cyc, done_cyc, bad_wr, done_cnt;
      cog_ena = 1'b1; cog_w = 1'b1; cog_a = 9'h010; cog_d = 32'hDEAD_BEEF;
      ack_mode = 2;
      start_load(14'h0300);
      cyc = 1; done_cyc = -1; bad_wr = 0; done_cnt = 0;
      while (done_cyc < 0 && cyc < LIMIT) begin
         if (busy && ram_ena && ram_w && ram_a == 9'h010) bad_wr++;
         if (cyc == 4) begin ptr = 14'h0000; start = 1'b1; end
         if (cyc == 5) start = 1'b0;
         if (done === 1'b1) begin done_cyc = cyc; done_cnt++; end
         else begin @(negedge clk); cyc++; end
      end
      @(negedge clk);
      n_cmp++;
      if ({busy, ram_ena, ram_w, ram_a, ram_d} !== {1'b0, 1'b1, 1'b1, 9'h010, 32'hDEAD_BEEF}) begin
         n_bad++;
         $display("FAIL arb_passthrough: busy=%b ram=%b %b %h %h, required 0 1 1 010 DEADBEEF",
                  busy, ram_ena, ram_w, ram_a, ram_d);
      end
      repeat (5) begin
         @(negedge clk);
         if (done === 1'b1) done_cnt++;
      end
      n_cmp++;
      if (bad_wr != 0) begin
         n_bad++;
         $display("FAIL arb_no_cog_write: %0d cog writes while busy, required 0", bad_wr);
      end
      n_cmp++;
      if (done_cyc != 9 + ZF4 || done_cnt != 1) begin
         n_bad++;
         $display("FAIL arb_done: cycle %0d pulses %0d, required %0d 1", done_cyc, done_cnt, 9 + ZF4);
      end
      n_cmp++;
      if (mem[1] !== 32'hA000_0301 || mem[3] !== 32'hA000_0303) begin
         n_bad++;
         $display("FAIL arb_ptr_kept: ram[1]=%h ram[3]=%h, required A0000301 A0000303", mem[1], mem[3]);
      end
      cog_ena = 1'b0; cog_w = 1'b0;
      ack_mode = 0;
   endtask

   task automatic test_reset_midload;
      int cyc, done_cyc, done_cnt, first_a;
      logic [31:0] first_d;
      ack_mode = 0;
      start_load(14'h0400);
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({ram_w, ram_a} !== {1'b1, 9'd1}) begin
         n_bad++;
         $display("FAIL rst_in_write2: ram_w=%b ram_a=%h, required 1 001", ram_w, ram_a);
      end
      nres = 1'b0;
      #1;
      n_cmp++;
      if ({busy, hub_req, done, ram_ena} !== 4'b0000) begin
         n_bad++;
         $display("FAIL rst_immediate: busy=%b hub_req=%b done=%b ram_ena=%b, required 0 0 0 0",
                  busy, hub_req, done, ram_ena);
      end
      @(negedge clk);
      nres = 1'b1;
      done_cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) done_cnt++;
      end
      n_cmp++;
      if (done_cnt != 0) begin
         n_bad++;
         $display("FAIL rst_no_done: %0d cycles with done or busy, required 0", done_cnt);
      end
      start_load(14'h0500);
      n_cmp++;
      if (hub_adr !== 14'h0500) begin
         n_bad++;
         $display("FAIL rst_reload_adr: hub_adr=%h, required 0500", hub_adr);
      end
      cyc = 1; done_cyc = -1; first_a = -1; first_d = 32'd0;
      while (done_cyc < 0 && cyc < LIMIT) begin
         if (ram_ena && ram_w && first_a < 0) begin
            first_a = int'(ram_a);
            first_d = ram_d;
         end
         if (done === 1'b1) done_cyc = cyc;
         else begin @(negedge clk); cyc++; end
      end
      n_cmp++;
      if (first_a != 0 || first_d !== 32'hA000_0500 || done_cyc != 9 + ZF4) begin
         n_bad++;
         $display("FAIL rst_reload: first write a=%0d d=%h done %0d, required 0 A0000500 %0d",
                  first_a, first_d, done_cyc, 9 + ZF4);
      end
      @(negedge clk);
   endtask

   task automatic test_full_512;
      int cyc, done_cyc, writes, last_a;
      logic [31:0] last_d;
      @(negedge clk);
      ptr2 = 14'h1000;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      cyc = 1; done_cyc = -1; writes = 0; last_a = -1; last_d = 32'd0;
      while (done_cyc < 0 && cyc < 1200) begin
         if (ram_ena2 && ram_w2) begin
            writes++;
            last_a = int'(ram_a2);
            last_d = ram_d2;
         end
         if (done2 === 1'b1) done_cyc = cyc;
         else begin @(negedge clk); cyc++; end
      end
      n_cmp++;
      if (done_cyc != 1025 || writes != 512) begin
         n_bad++;
         $display("FAIL full512_done: cycle %0d writes %0d, required 1025 512", done_cyc, writes);
      end
      n_cmp++;
      if (last_a != 511 || last_d !== 32'h5A00_11FF) begin
         n_bad++;
         $display("FAIL full512_last: a=%0d d=%h, required 511 5A0011FF", last_a, last_d);
      end
      @(negedge clk);
   endtask

`ifdef COG_LOADER_ZERO_EN
   task automatic test_zero_fill;
      int cyc, done_cyc, zeros, bad;
      @(negedge clk);
      ptr3 = 14'h2000;
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      cyc = 1; done_cyc = -1; zeros = 0; bad = 0;
      while (done_cyc < 0 && cyc < 1200) begin
         if (ram_ena3 && ram_w3) begin
            if (ram_a3 >= 9'd496) begin
               if (ram_d3 === 32'd0) zeros++;
               else bad++;
            end else if (ram_d3 !== (32'hC000_2000 + {23'd0, ram_a3})) begin
               bad++;
            end
         end
         if (done3 === 1'b1) done_cyc = cyc;
         else begin @(negedge clk); cyc++; end
      end
      n_cmp++;
      if (zeros != 16 || bad != 0) begin
         n_bad++;
         $display("FAIL zero_fill: zero writes %0d bad writes %0d, required 16 0", zeros, bad);
      end
      n_cmp++;
      if (done_cyc != 1009) begin
         n_bad++;
         $display("FAIL zero_done: done at cycle %0d, required 1009", done_cyc);
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      start = 1'b0; ptr = 14'd0; start2 = 1'b0; ptr2 = 14'd0;
`ifdef COG_LOADER_ZERO_EN
      start3 = 1'b0; ptr3 = 14'd0;
`endif
      cog_ena = 1'b0; cog_w = 1'b0; cog_a = 9'd0; cog_d = 32'd0;
      nres = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_ack_latency();
      test_wrap();
      test_arbitration();
      test_reset_midload();
      test_full_512();
`ifdef COG_LOADER_ZERO_EN
      test_zero_fill();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cog_loader.md
# cog_loader

Sequences cog start-up: on a start pulse it copies `LOAD_LONGS` consecutive longs from hub memory into the cog's 512 x 32 cog RAM, then hands the RAM port back to the cog pipeline. It sits between the hub interface and the cog RAM instance. It owns the single RAM port while busy and otherwise passes the cog pipeline's port straight through, so it acts as both sequencer and port arbiter for cog RAM.

## Interface
Parameters:
- `LOAD_LONGS`, 496: number of longs loaded; legal range 1..512.
- `HUB_AW`, 14: hub long-address width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `nres`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle load request; ignored while `busy`.
- `ptr`  in  HUB_AW  hub long address of image base; captured on accepted `start`.
- `busy`  out  1  load in progress; cog RAM owned by loader.
- `done`  out  1  one-cycle pulse when the load completes.
- `hub_req`  out  1  hub read request.
- `hub_adr`  out  HUB_AW  hub long address; stable while `hub_req`.
- `hub_ack`  in  1  hub grant; `hub_q` is valid in the same cycle.
- `hub_q`  in  32  hub read data.
- `cog_ena`, `cog_w`  in  1 each  cog pipeline RAM enable and write.
- `cog_a`  in  9  cog pipeline RAM address.
- `cog_d`  in  32  cog pipeline RAM write data.
- `ram_ena`, `ram_w`  out  1 each  to cog RAM.
- `ram_a`  out  9  to cog RAM.
- `ram_d`  out  32  to cog RAM.

## Operation
- States: IDLE, REQ, WRITE, ZERO (only with the macro defined), DONE.
- Registered state: `base`, `cnt` (10 bits), `data` (32 bits).

Transitions:
- **IDLE:** on `start`, capture `base`=`ptr`, set `cnt`=0, go to REQ.
- **REQ:** drive `hub_req`=1 and `hub_adr`=(`base`+`cnt`) mod 2^HUB_AW.
  - If `hub_ack`: capture `data`=`hub_q` and go to WRITE.
  - Otherwise hold REQ indefinitely with `hub_adr` unchanged.
- **WRITE:** drive a RAM write with `ram_a`=`cnt`[8:0] and `ram_d`=`data`.
  - If `cnt`==LOAD_LONGS-1, go to ZERO (macro defined and LOAD_LONGS<512) or DONE.
  - Otherwise increment `cnt` and go to REQ.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.

Outputs and arbitration:
- `busy`=1 in every state except IDLE.
- RAM port mux is combinational on state:
  - While `busy`, the loader drives `ram_*`. Outside a RAM write (ZERO or WRITE) it drives `ram_ena`=0 and `ram_w`=0.
  - While idle, `ram_*` equals `cog_*` exactly.
- Cog requests during `busy` are dropped; the cog pipeline must be held off by `busy`.

Boundary conditions:
- `start` while `busy`: ignored. `ptr` is not re-captured.
- Hub address wrap: `base`+`cnt` wraps modulo 2^HUB_AW silently.
- LOAD_LONGS=512: last write goes to address 511; ZERO is skipped.
- `hub_ack` outside REQ: ignored.

Reset:
- Any state returns to IDLE.
- `busy`, `done`, `hub_req`, `base`, `cnt`, `data` and `hub_adr` all reset to 0.
- After reset, `ram_*` follows `cog_*`.
- A partial load is abandoned and no `done` is produced.

## Timing
- `start` sampled high at edge 0 → REQ from cycle 1: `busy`=1 and `hub_req`=1.
- `hub_ack` in REQ cycle k → WRITE in cycle k+1 (`ram_w`=1, `hub_req`=0) → next REQ in cycle k+2.
- Minimum rate is 2 cycles per long, when ack arrives in the first REQ cycle.
- Minimum load time is 2·LOAD_LONGS + 1 cycles from `start` to `done`, plus 512−LOAD_LONGS cycles with zero-fill.
- `done` is asserted in the cycle after the last write; `busy` is still 1 in that DONE cycle.
- `busy` falls 1 cycle after `done`. A `start` in the cycle `busy` first reads 0 is accepted.

## Configuration
- `COG_LOADER_ZERO_EN`:
  - Defined: after the last load write, state ZERO writes 32'h0 to addresses LOAD_LONGS..511, one per cycle, with `cnt` continuing to count. DONE follows the write to 511.
  - Undefined: no ZERO state; addresses ≥LOAD_LONGS keep their prior contents.

## Test plan
- **Basic load:** LOAD_LONGS=4, `ptr`=14'h0100, hub returns 32'hA000_0000+adr with immediate ack.
  - → Writes to RAM 0..3 of A000_0100..A000_0103.
  - → `done` at cycle 9 after `start`.
- **Ack latency:** hub acks 3 cycles after each `hub_req` rise.
  - → `hub_adr` is stable while `hub_req`=1.
  - → Exactly one write per ack; total 20 cycles for 4 longs.
- **Address wrap:** `ptr`=14'h3FFE, LOAD_LONGS=4 → hub addresses 3FFE, 3FFF, 0000, 0001.
- **Arbitration:** `cog_ena`=1, `cog_w`=1, `cog_a`=9'h010 held throughout a load.
  - → No RAM write at 9'h010 while `busy`.
  - → Passthrough restored the cycle after `busy` falls.
  - → `start` pulsed mid-load is ignored.
- **Reset mid-load:** drop `nres` during the 2nd WRITE.
  - → `busy`, `hub_req` and `done` are 0 immediately.
  - → No `done` afterwards.
  - → A new `start` reloads from address 0.
- **Zero-fill:** with `COG_LOADER_ZERO_EN` and LOAD_LONGS=496.
  - → Addresses 496..511 read 32'h0.
  - → `done` at cycle 2·496+1+16 after `start`.
